des_round_engine: RTL and testbench

//  Iterative, parametrised DES/Feistel core running all 16 rounds on one block.

---
 rtl/des_round_engine_pkg.sv | 94 +++++++++
 rtl/des_round_engine_round_comb.sv | 71 +++++++
 rtl/des_round_engine.sv | 158 +++++++++++++++
 tb/tb_des_round_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_round_engine_pkg.sv
// Shared definitions for the DES round engine: state encoding, widths,
// the key shift schedule and the fixed DES permutation / S-box tables.
// Table entries use DES bit numbering (bit 1 = MSB of the vector).
package des_round_engine_pkg;

    localparam int HALF_W = 32;
    localparam int KEY_W  = 56;
    localparam int SUBK_W = 48;
    localparam int CD_W   = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expansion E: 32 -> 48 bits
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    // Permutation P applied to the S-box outputs
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // PC2: 56-bit {C,D} -> 48-bit round subkey
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28,
        15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56,
        34, 53, 46, 42, 50, 36, 29, 32
    };

    // S-boxes S1..S8; entry (row*16+col) is nibble number k counted from the MSB
    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Key-schedule rotation for round j (1..16): one position on rounds 1,2,9,16
    function automatic logic [1:0] des_shift(input logic [4:0] j);
        case (j)
            5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

    // Row is the outer bit pair, column the middle four bits
    function automatic logic [3:0] des_sbox(input logic [255:0] tab, input logic [5:0] b);
        logic [5:0]   k;
        logic [7:0]   sh;
        logic [255:0] t;
        k  = {b[5], b[0], b[4:1]};
        sh = 8'd252 - {k, 2'b00};
        t  = tab >> sh;
        return t[3:0];
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[CD_W-2:0], x[CD_W-1]};
            2'd2:    return {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[CD_W-1:1]};
            2'd2:    return {x[1:0], x[CD_W-1:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_round_engine_round_comb.sv
// One combinational DES round: key rotation, PC2, expansion, key mix,
// S-box substitution and P permutation. Cascaded by the engine to unroll rounds.
module des_round_engine_round_comb
    import des_round_engine_pkg::*;
(
    input  logic [HALF_W-1:0] left,
    input  logic [HALF_W-1:0] right,
    input  logic [KEY_W-1:0]  cd_in,
    input  logic              decrypt,
    input  logic [4:0]        round_idx,
    output logic [HALF_W-1:0] left_o,
    output logic [HALF_W-1:0] right_o,
    output logic [KEY_W-1:0]  cd_o
);

    logic [1:0]        shift_amt;
    logic [CD_W-1:0]   c_rot;
    logic [CD_W-1:0]   d_rot;
    logic [SUBK_W-1:0] subkey;
    logic [SUBK_W-1:0] e_out;
    logic [SUBK_W-1:0] mixed;
    logic [HALF_W-1:0] s_out;
    logic [HALF_W-1:0] f_out;

    // Decrypt walks the schedule backwards: round 1 uses the unrotated key (K16)
    always_comb begin
        shift_amt = 2'd0;
        if (!decrypt) begin
            shift_amt = des_shift(round_idx);
        end else if (round_idx != 5'd1) begin
            shift_amt = des_shift(5'd18 - round_idx);
        end
    end

    // Rotate C and D independently; the rotated pair feeds this round and the next
    always_comb begin
        if (decrypt) begin
            c_rot = rotr28(cd_in[KEY_W-1:CD_W], shift_amt);
            d_rot = rotr28(cd_in[CD_W-1:0], shift_amt);
        end else begin
            c_rot = rotl28(cd_in[KEY_W-1:CD_W], shift_amt);
            d_rot = rotl28(cd_in[CD_W-1:0], shift_amt);
        end
    end

    assign cd_o = {c_rot, d_rot};

    genvar gi;

    for (gi = 0; gi < SUBK_W; gi++) begin : g_pc2
        assign subkey[SUBK_W-1-gi] = cd_o[KEY_W-PC2_TAB[gi]];
    end

    for (gi = 0; gi < SUBK_W; gi++) begin : g_expand
        assign e_out[SUBK_W-1-gi] = right[HALF_W-E_TAB[gi]];
    end

    assign mixed = e_out ^ subkey;

    for (gi = 0; gi < 8; gi++) begin : g_sbox
        assign s_out[HALF_W-1-4*gi -: 4] = des_sbox(SBOX_TAB[gi], mixed[SUBK_W-1-6*gi -: 6]);
    end

    for (gi = 0; gi < HALF_W; gi++) begin : g_perm
        assign f_out[HALF_W-1-gi] = s_out[HALF_W-P_TAB[gi]];
    end

    assign left_o  = right;
    assign right_o = left ^ f_out;

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: accepts post-IP halves and a post-PC1 key,
// runs 16 rounds at ROUNDS_PER_CYCLE rounds per clock and returns the
// swapped preoutput {R16,L16} for the final permutation.
module des_round_engine
    import des_round_engine_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CNT_W            = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [HALF_W-1:0]   in_left,
    input  logic [HALF_W-1:0]   in_right,
    input  logic [KEY_W-1:0]    in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_data,
    output logic                busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_rpc_check
        $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   left_q, left_d;
    logic [HALF_W-1:0]   right_q, right_d;
    logic [KEY_W-1:0]    cd_q, cd_d;
    logic [CNT_W-1:0]    round_cnt_q, round_cnt_d;
    logic [2*HALF_W-1:0] out_data_q, out_data_d;
    logic                decrypt_q, decrypt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [CNT_W-1:0]    cnt_sum;

    // Round chain; element 0 is the registered state, element N the result after N rounds
    logic [HALF_W-1:0]   chain_left  [ROUNDS_PER_CYCLE+1];
    logic [HALF_W-1:0]   chain_right [ROUNDS_PER_CYCLE+1];
    logic [KEY_W-1:0]    chain_cd    [ROUNDS_PER_CYCLE+1];

    assign chain_left[0]  = left_q;
    assign chain_right[0] = right_q;
    assign chain_cd[0]    = cd_q;

    genvar gi;

    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
        logic [4:0] round_idx;
        assign round_idx = 5'(round_cnt_q + CNT_W'(gi + 1));

        des_round_engine_round_comb u_round (
            .left      (chain_left[gi]),
            .right     (chain_right[gi]),
            .cd_in     (chain_cd[gi]),
            .decrypt   (decrypt_q),
            .round_idx (round_idx),
            .left_o    (chain_left[gi+1]),
            .right_o   (chain_right[gi+1]),
            .cd_o      (chain_cd[gi+1])
        );
    end

    assign cnt_sum = round_cnt_q + CNT_W'(ROUNDS_PER_CYCLE);

    // Next-state and datapath: accept in IDLE, iterate in RUN, hold result in DONE
    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        cd_d        = cd_q;
        round_cnt_d = round_cnt_q;
        out_data_d  = out_data_q;
        decrypt_d   = decrypt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    left_d      = in_left;
                    right_d     = in_right;
                    cd_d        = in_key;
                    decrypt_d   = in_decrypt;
                    round_cnt_d = '0;
                    state_d     = ST_RUN;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                left_d      = chain_left[ROUNDS_PER_CYCLE];
                right_d     = chain_right[ROUNDS_PER_CYCLE];
                cd_d        = chain_cd[ROUNDS_PER_CYCLE];
                round_cnt_d = cnt_sum;
                if (cnt_sum == CNT_W'(16)) begin
                    // Halves are swapped only here, never between rounds
                    out_data_d  = {chain_right[ROUNDS_PER_CYCLE], chain_left[ROUNDS_PER_CYCLE]};
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            left_q      <= '0;
            right_q     <= '0;
            cd_q        <= '0;
            round_cnt_q <= '0;
            out_data_q  <= '0;
            decrypt_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            cd_q        <= cd_d;
            round_cnt_q <= round_cnt_d;
            out_data_q  <= out_data_d;
            decrypt_q   <= decrypt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine using the classic DES worked example.
// One instance at one round per clock drives the protocol tests; four more
// instances cover the unrolled variants.
module tb_des_round_engine;

    localparam logic [55:0] KEY     = 56'hF0CCAAF_556678F;
    localparam logic [31:0] PT_L    = 32'hCC00CCFF;
    localparam logic [31:0] PT_R    = 32'hF0AAF0AA;
    localparam logic [31:0] CT_L    = 32'h0A4CD995;
    localparam logic [31:0] CT_R    = 32'h43423234;
    localparam logic [63:0] ENC_EXP = 64'h0A4CD995_43423234;
    localparam logic [63:0] DEC_EXP = 64'hCC00CCFF_F0AAF0AA;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [55:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    logic        m_in_valid;
    logic        m_out_ready;
    logic        m_in_ready  [4];
    logic        m_out_valid [4];
    logic [63:0] m_out_data  [4];
    logic        m_busy      [4];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS_PER_CYCLE(1), .CNT_W(5)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_rpc
        des_round_engine #(.ROUNDS_PER_CYCLE(2 << gi), .CNT_W(5)) u_dut_rpc (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (m_in_valid),
            .in_ready   (m_in_ready[gi]),
            .in_decrypt (in_decrypt),
            .in_left    (in_left),
            .in_right   (in_right),
            .in_key     (in_key),
            .out_valid  (m_out_valid[gi]),
            .out_ready  (m_out_ready),
            .out_data   (m_out_data[gi]),
            .busy       (m_busy[gi])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drive(input logic dec, input logic [31:0] l, input logic [31:0] r);
        in_decrypt = dec;
        in_left    = l;
        in_right   = r;
        in_key     = KEY;
    endtask

    // Full transaction on the single-round instance
    task automatic run_block(input string tag, input logic dec, input logic [31:0] l,
                             input logic [31:0] r, input logic [63:0] exp);
        int n;
        drive(dec, l, r);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " in_ready after accept"}, 64'(in_ready), 64'd0);
        check({tag, " busy after accept"}, 64'(busy), 64'd1);
        wait_valid(n);
        check({tag, " latency"}, 64'(n), 64'd16);
        check({tag, " out_data"}, out_data, exp);
        $display("txn %s: dec=%0d in=%h_%h out=%h latency=%0d", tag, dec, l, r, out_data, n);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
        check({tag, " busy after handshake"}, 64'(busy), 64'd0);
    endtask

    // Same block into all unrolled instances; each must raise out_valid at 16/RPC clks
    task automatic multi_block(input string tag, input logic dec, input logic [31:0] l,
                               input logic [31:0] r, input logic [63:0] exp);
        int lat;
        drive(dec, l, r);
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s rpc%0d valid at accept", tag, 2 << k), 64'(m_out_valid[k]), 64'd0);
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                lat = 8 >> k;
                if (c == lat) begin
                    check($sformatf("%s rpc%0d valid", tag, 2 << k), 64'(m_out_valid[k]), 64'd1);
                    check($sformatf("%s rpc%0d data", tag, 2 << k), m_out_data[k], exp);
                    $display("txn %s rpc%0d: out=%h at clk %0d", tag, 2 << k, m_out_data[k], c);
                end else if (c == lat - 1) begin
                    check($sformatf("%s rpc%0d early valid", tag, 2 << k), 64'(m_out_valid[k]), 64'd0);
                end
            end
        end
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s rpc%0d valid after handshake", tag, 2 << k), 64'(m_out_valid[k]), 64'd0);
            check($sformatf("%s rpc%0d ready after handshake", tag, 2 << k), 64'(m_in_ready[k]), 64'd1);
            check($sformatf("%s rpc%0d busy after handshake", tag, 2 << k), 64'(m_busy[k]), 64'd0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion before 50000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_data", out_data, 64'd0);
        $display("txn reset: in_ready=%0d out_valid=%0d busy=%0d", in_ready, out_valid, busy);
        rst = 1'b0;
        tick();

        // Encrypt and decrypt, one round per clock
        run_block("enc", 1'b0, PT_L, PT_R, ENC_EXP);
        run_block("dec", 1'b1, CT_L, CT_R, DEC_EXP);

        // Unrolled variants
        multi_block("menc", 1'b0, PT_L, PT_R, ENC_EXP);
        multi_block("mdec", 1'b1, CT_L, CT_R, DEC_EXP);

        // Backpressure in DONE with in_valid pulses that must be ignored
        drive(1'b0, PT_L, PT_R);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp latency", 64'(n), 64'd16);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_left  = 32'hDEADBEEF;
            tick();
            check($sformatf("bp valid c%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp data c%0d", i), out_data, ENC_EXP);
            check($sformatf("bp in_ready c%0d", i), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        $display("txn backpressure: out=%h held 5 clks", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp valid after handshake", 64'(out_valid), 64'd0);
        check("bp busy after handshake", 64'(busy), 64'd0);
        tick();
        check("bp no stray accept", 64'(in_ready), 64'd1);

        // Back-to-back with in_valid held high and out_ready high
        drive(1'b0, PT_L, PT_R);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(1'b1, CT_L, CT_R);
        wait_valid(n);
        check("b2b first latency", 64'(n), 64'd16);
        check("b2b first data", out_data, ENC_EXP);
        $display("txn b2b first: out=%h", out_data);
        tick();
        check("b2b idle valid", 64'(out_valid), 64'd0);
        check("b2b idle in_ready", 64'(in_ready), 64'd1);
        tick();
        check("b2b second accepted", 64'(in_ready), 64'd0);
        check("b2b second busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
        wait_valid(n);
        check("b2b second latency", 64'(n), 64'd16);
        check("b2b second data", out_data, DEC_EXP);
        $display("txn b2b second: out=%h", out_data);
        tick();
        check("b2b second drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Mode is latched at accept; in_decrypt toggles during RUN
        drive(1'b0, PT_L, PT_R);
        in_valid = 1'b1;
        tick();
        in_valid   = 1'b0;
        in_decrypt = 1'b1;
        tick();
        tick();
        in_decrypt = 1'b0;
        tick();
        in_decrypt = 1'b1;
        wait_valid(n);
        check("mode latency", 64'(n), 64'd13);
        check("mode data", out_data, ENC_EXP);
        $display("txn mode latch: out=%h", out_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a block
        drive(1'b0, PT_L, PT_R);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst out_data", out_data, 64'd0);
        $display("txn reset mid-run: in_ready=%0d busy=%0d", in_ready, busy);
        tick();
        rst = 1'b0;
        tick();
        run_block("post-reset dec", 1'b1, CT_L, CT_R, DEC_EXP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
